// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: MEM stage to word-organised data memory.
// Alignment check, lane steering, req/ack with watchdog abort.
module lsu_mem_initiator #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS+1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [DM_ADDRESS-1:0] a_q, a_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic [DATA_W-1:0]     rd_q, rd_d;
  logic                  err_q, err_d;
  logic [WW-1:0]         wdog_q, wdog_d;

  logic                  illegal;
  logic                  misal;
  logic [3:0]            be_c;
  logic [DATA_W-1:0]     wd_c;
  logic [DATA_W-1:0]     lane;
  logic [DATA_W-1:0]     ld_c;

  always_comb begin
    illegal = (Funct3 == 3'b011) ||
              (Funct3[2:1] == 2'b11) ||
              (MemWrite && Funct3[2]);
    misal   = ((Funct3[1:0] == 2'b01) && addr[0]) ||
              ((Funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    be_c = 4'b1111;
    wd_c = wd;
    if (MemWrite) begin
      unique case (Funct3[1:0])
        2'b00: begin
          be_c = 4'b0001 << addr[1:0];
          wd_c = {24'b0, wd[7:0]} << {addr[1:0], 3'b000};
        end
        2'b01: begin
          be_c = 4'b0011 << addr[1:0];
          wd_c = {16'b0, wd[15:0]} << {addr[1:0], 3'b000};
        end
        default: begin
          be_c = 4'b1111;
          wd_c = wd;
        end
      endcase
    end else begin
      wd_c = '0;
    end
  end

  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_c = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_c = {24'b0, lane[7:0]};
      3'b001:  ld_c = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_c = {16'b0, lane[15:0]};
      default: ld_c = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    a_d     = a_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && (MemRead || MemWrite)) begin
          if (illegal || misal) begin
            err_d   = 1'b1;
            rd_d    = '0;
            state_d = S_DONE;
          end else begin
            we_d    = MemWrite;
            f3_d    = Funct3;
            off_d   = addr[1:0];
            a_d     = addr[DM_ADDRESS+1:2];
            be_d    = be_c;
            wd_d    = wd_c;
            wdog_d  = '0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // ack beats a timeout landing in the same cycle
        if (mem_ack) begin
          err_d   = 1'b0;
          rd_d    = we_q ? '0 : ld_c;
          state_d = S_DONE;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rd_d    = '0;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      a_q     <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      a_q     <= a_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = mem_req && we_q;
  assign mem_be    = be_q;
  assign mem_a     = a_q;
  assign mem_wd    = wd_q;
  assign done      = (state_q == S_DONE);
  assign err       = done && err_q;
  assign rd        = rd_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: vector table plus
// hand sequences for ignored request and reset mid-access.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  Funct3 = '0;
  logic [10:0] addr = '0;
  logic [31:0] wd = '0;
  logic        done;
  logic        err;
  logic [31:0] rd;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [8:0]  mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int nvec = 0;
  int nbad = 0;

  lsu_mem_initiator #(
    .DM_ADDRESS(9),
    .DATA_W(32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .req_valid(req_valid), .req_ready(req_ready),
    .Funct3(Funct3), .addr(addr), .wd(wd),
    .done(done), .err(err), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdq;
    logic        we;
    logic [2:0]  f3;
    logic [10:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ackn;
    logic        xacc;
    logic        xerr;
    logic [31:0] xrd;
    logic [8:0]  xa;
    logic [3:0]  xbe;
    logic [31:0] xwd;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run(input int id, input vec_t v);
    int lat, nreq;
    logic got, first, errv, mrq;
    logic [31:0] rdv, ca, cbe, cwd, cwe;
    string p;
    p = $sformatf("v%0d", id);
    lat = 0; nreq = 0; got = 0; first = 1;
    errv = 0; mrq = 0; rdv = 0;
    ca = 0; cbe = 0; cwd = 0; cwe = 0;
    chk({p, " ready"}, 32'(req_ready), 32'd1);
    MemRead = v.rdq; MemWrite = v.we;
    Funct3 = v.f3; addr = v.addr; wd = v.wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        got = 1; errv = err; rdv = rd; mrq = mem_req;
      end else if (mem_req) begin
        nreq++;
        if (first) begin
          ca = 32'(mem_a); cbe = 32'(mem_be);
          cwd = mem_wd; cwe = 32'(mem_we);
          first = 0;
        end
        if (v.ackn != 0 && nreq == v.ackn) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
        end
      end
    end
    mem_ack = 1'b0;
    chk({p, " done_seen"}, 32'(got), 32'd1);
    chk({p, " latency"}, 32'(lat),
        v.xacc ? ((v.ackn == 0) ? 32'd5 : 32'(v.ackn + 1)) : 32'd1);
    chk({p, " req_cycles"}, 32'(nreq),
        v.xacc ? ((v.ackn == 0) ? 32'd4 : 32'(v.ackn)) : 32'd0);
    chk({p, " err"}, 32'(errv), 32'(v.xerr));
    chk({p, " rd"}, rdv, v.xrd);
    chk({p, " req_at_done"}, 32'(mrq), 32'd0);
    if (v.xacc) begin
      chk({p, " mem_a"}, ca, 32'(v.xa));
      chk({p, " mem_be"}, cbe, 32'(v.xbe));
      chk({p, " mem_we"}, cwe, 32'(v.we));
      if (v.we) chk({p, " mem_wd"}, cwd, v.xwd);
    end
    @(negedge clk);
    chk({p, " done_pulse"}, 32'(done), 32'd0);
    chk({p, " rd_hold"}, rd, v.xrd);
  endtask

  initial begin
    tv[0]  = '{1,0,3'b010,11'h010,0,32'hDEADBEEF,1,1,0,32'hDEADBEEF,9'd4,4'hF,0};
    tv[1]  = '{1,0,3'b000,11'h013,0,32'h80112233,1,1,0,32'hFFFFFF80,9'd4,4'hF,0};
    tv[2]  = '{1,0,3'b100,11'h013,0,32'h80112233,2,1,0,32'h00000080,9'd4,4'hF,0};
    tv[3]  = '{1,0,3'b101,11'h012,0,32'h80112233,3,1,0,32'h00008011,9'd4,4'hF,0};
    tv[4]  = '{1,0,3'b001,11'h012,0,32'h80112233,1,1,0,32'hFFFF8011,9'd4,4'hF,0};
    tv[5]  = '{0,1,3'b000,11'h005,32'h000000AB,0,1,1,0,0,9'd1,4'b0010,32'h0000AB00};
    tv[6]  = '{0,1,3'b001,11'h006,32'h00001234,0,2,1,0,0,9'd1,4'b1100,32'h12340000};
    tv[7]  = '{1,1,3'b010,11'h008,32'hCAFEF00D,32'h11111111,1,1,0,0,9'd2,4'hF,32'hCAFEF00D};
    tv[8]  = '{1,0,3'b010,11'h002,0,0,1,0,1,0,0,0,0};
    tv[9]  = '{0,1,3'b001,11'h001,32'h00001234,0,1,0,1,0,0,0,0};
    tv[10] = '{1,0,3'b011,11'h000,0,0,1,0,1,0,0,0,0};
    tv[11] = '{0,1,3'b100,11'h000,32'h55,0,1,0,1,0,0,0,0};
    tv[12] = '{1,0,3'b010,11'h01C,0,32'h12345678,0,1,1,0,9'd7,4'hF,0};
    tv[13] = '{1,0,3'b010,11'h01C,0,32'h12345678,4,1,0,32'h12345678,9'd7,4'hF,0};
    tv[14] = '{1,0,3'b000,11'h000,0,32'h0000007F,1,1,0,32'h0000007F,9'd0,4'hF,0};
    tv[15] = '{0,1,3'b000,11'h7FF,32'hFFFFFFC3,0,1,1,0,0,9'h1FF,4'b1000,32'hC3000000};
    tv[16] = '{1,0,3'b101,11'h002,0,32'hABCD1234,2,1,0,32'h0000ABCD,9'd0,4'hF,0};

    #12;
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_a", 32'(mem_a), 32'd0);
    chk("rst mem_wd", mem_wd, 32'd0);
    chk("rst rd", rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) run(i, tv[i]);

    // strobe without MemRead/MemWrite must be ignored
    req_valid = 1'b1; Funct3 = 3'b010; addr = 11'h010;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ign done", 32'(done), 32'd0);
      chk("ign req", 32'(mem_req), 32'd0);
      chk("ign ready", 32'(req_ready), 32'd1);
      @(negedge clk);
    end

    // reset pulse in the middle of an access
    MemRead = 1'b1; Funct3 = 3'b010; addr = 11'h010;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    chk("mid req_up", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid req_drop", 32'(mem_req), 32'd0);
    chk("mid ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post done", 32'(done), 32'd0);
    chk("post req", 32'(mem_req), 32'd0);
    run(100, tv[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
